// File: rtl/multicycle_ctrl_fsm_pkg.sv
// ctrl_pkg: shared types and encodings for the multicycle control sequencer.
// Holds the state enum, opcode numbers, ALUop classes and select encodings.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  // opcodes (IR opcode field); anything above OP_BNCY is illegal
  localparam int unsigned OP_ALU  = 0;
  localparam int unsigned OP_ALUI = 1;
  localparam int unsigned OP_LW   = 2;
  localparam int unsigned OP_SW   = 3;
  localparam int unsigned OP_BR   = 4;
  localparam int unsigned OP_BLTZ = 5;
  localparam int unsigned OP_BZ   = 6;
  localparam int unsigned OP_BNZ  = 7;
  localparam int unsigned OP_B    = 8;
  localparam int unsigned OP_BL   = 9;
  localparam int unsigned OP_BCY  = 10;
  localparam int unsigned OP_BNCY = 11;

  // ALUop classes (zero-extended onto the ALUop port)
  localparam logic [1:0] ALUC_REG  = 2'b00;
  localparam logic [1:0] ALUC_IMM  = 2'b01;
  localparam logic [1:0] ALUC_ADDR = 2'b10;
  localparam logic [1:0] ALUC_BR   = 2'b11;

  // next-PC source
  localparam logic [1:0] ASEL_PC4   = 2'b00;
  localparam logic [1:0] ASEL_REG   = 2'b01;
  localparam logic [1:0] ASEL_PCREL = 2'b10;
  localparam logic [1:0] ASEL_ABS   = 2'b11;

  // destination register select
  localparam logic [1:0] RDST_RD   = 2'b00;
  localparam logic [1:0] RDST_RT   = 2'b01;
  localparam logic [1:0] RDST_LINK = 2'b10;

  // write-back source select
  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  function automatic logic op_legal(input int unsigned op);
    return op <= OP_BNCY;
  endfunction

  function automatic logic [1:0] alu_class(input int unsigned op);
    case (op)
      OP_ALU:        return ALUC_REG;
      OP_ALUI:       return ALUC_IMM;
      OP_LW, OP_SW:  return ALUC_ADDR;
      default:       return ALUC_BR;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Memory handshake bundle: instruction fetch and data access req/ready pairs.
// master = sequencer side, slave = memory side.
interface multicycle_ctrl_fsm_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_ready;
  logic MemRead;
  logic MemWrite;

  modport master (
    output imem_req, dmem_req, MemRead, MemWrite,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req, MemRead, MemWrite,
    output imem_ready, dmem_ready
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_branch_cond_eval.sv
// branch_cond_eval: combinational branch resolution from opcode and the
// latched ALU flags. Non-branch opcodes report not-taken, PC+4.
module branch_cond_eval
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_c,
  input  logic                flag_z,
  input  logic                flag_s,
  output logic                taken,
  output logic [1:0]          addr_sel
);

  int unsigned op_i;
  assign op_i = 32'(opcode);

  // resolve direction and target source per branch opcode
  always_comb begin
    taken    = 1'b0;
    addr_sel = ASEL_PC4;
    case (op_i)
      OP_BR:       begin taken = 1'b1;    addr_sel = ASEL_REG;   end
      OP_BLTZ:     begin taken = flag_s;  addr_sel = ASEL_PCREL; end
      OP_BZ:       begin taken = flag_z;  addr_sel = ASEL_PCREL; end
      OP_BNZ:      begin taken = !flag_z; addr_sel = ASEL_PCREL; end
      OP_B, OP_BL: begin taken = 1'b1;    addr_sel = ASEL_ABS;   end
      OP_BCY:      begin taken = flag_c;  addr_sel = ASEL_ABS;   end
      OP_BNCY:     begin taken = !flag_c; addr_sel = ASEL_ABS;   end
      default:     ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: FETCH/DECODE/EXEC/MEM/WB sequencer for KGPminiRISC.
// Moore outputs decoded from state + IR opcode; counts retired instructions.
// Optional: CTRL_ILLEGAL_TRAP_EN sends illegal opcodes to a sticky TRAP
// state; without it illegal opcodes retire as NOPs and illegal stays 0.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 4,
  parameter int CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 flag_c,
  input  logic                 flag_z,
  input  logic                 flag_s,
  multicycle_ctrl_fsm_if.master mem,
  output logic                 ir_write,
  output logic                 RegWrite,
  output logic [1:0]           RegDst,
  output logic [1:0]           MemToReg,
  output logic [ALUOP_W-1:0]   ALUop,
  output logic                 pc_write,
  output logic [1:0]           AddrSel,
  output logic                 illegal,
  output logic [CNT_W-1:0]     retired
);

  state_t      state, state_n;
  logic        retire;
  logic        br_taken;
  logic [1:0]  br_sel;
  logic        imem_req_c, dmem_req_c, mrd_c, mwr_c;
  int unsigned op_i;

  assign op_i = 32'(opcode);

  branch_cond_eval #(.OPCODE_W(OPCODE_W)) u_bce (
    .opcode   (opcode),
    .flag_c   (flag_c),
    .flag_z   (flag_z),
    .flag_s   (flag_s),
    .taken    (br_taken),
    .addr_sel (br_sel)
  );

  // state register; reset abandons any in-flight memory transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

  // next-state and Moore output decode
  always_comb begin
    state_n    = state;
    retire     = 1'b0;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    mrd_c      = 1'b0;
    mwr_c      = 1'b0;
    ir_write   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = RDST_RD;
    MemToReg   = M2R_ALU;
    ALUop      = '0;
    pc_write   = 1'b0;
    AddrSel    = ASEL_PC4;
    illegal    = 1'b0;
    case (state)
      S_IDLE: state_n = S_FETCH;
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (mem.imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          AddrSel  = ASEL_PC4;
          state_n  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_legal(op_i)) state_n = S_EXEC;
        else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_n = S_TRAP;
`else
          state_n = S_FETCH;
          retire  = 1'b1;
`endif
        end
      end
      S_EXEC: begin
        ALUop = ALUOP_W'(alu_class(op_i));
        case (op_i)
          OP_ALU, OP_ALUI: state_n = S_WB;
          OP_LW, OP_SW:    state_n = S_MEM;
          default: begin
            // all remaining legal opcodes are branches
            pc_write = br_taken;
            AddrSel  = br_sel;
            if (op_i == OP_BL) begin
              RegWrite = 1'b1;
              RegDst   = RDST_LINK;
              MemToReg = M2R_PC4;
            end
            state_n = S_FETCH;
            retire  = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        mrd_c      = (op_i == OP_LW);
        mwr_c      = (op_i == OP_SW);
        if (mem.dmem_ready) begin
          if (op_i == OP_LW) state_n = S_WB;
          else begin
            state_n = S_FETCH;
            retire  = 1'b1;
          end
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        if (op_i == OP_LW) begin
          RegDst   = RDST_RT;
          MemToReg = M2R_MEM;
        end
        state_n = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal = 1'b1;
`endif
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign mem.imem_req = imem_req_c;
  assign mem.dmem_req = dmem_req_c;
  assign mem.MemRead  = mrd_c;
  assign mem.MemWrite = mwr_c;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: table of single-instruction
// vectors plus hand sequences for memory waits, reset and counter wrap.
module tb_multicycle_ctrl_fsm;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [5:0] opcode;
  logic       flag_c, flag_z, flag_s;
  logic       ir_write, RegWrite, pc_write, illegal;
  logic [1:0] RegDst, MemToReg, AddrSel;
  logic [3:0] ALUop;
  logic [31:0] retired;

  multicycle_ctrl_fsm_if mif();

  multicycle_ctrl_fsm #(.OPCODE_W(6), .ALUOP_W(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .flag_c(flag_c), .flag_z(flag_z), .flag_s(flag_s),
    .mem(mif.master),
    .ir_write(ir_write), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemToReg(MemToReg), .ALUop(ALUop), .pc_write(pc_write),
    .AddrSel(AddrSel), .illegal(illegal), .retired(retired)
  );

  // narrow-counter instance for wrap checking
  logic       s_rst_n;
  logic       s_ir_write, s_RegWrite, s_pc_write, s_illegal;
  logic [1:0] s_RegDst, s_MemToReg, s_AddrSel;
  logic [3:0] s_ALUop;
  logic [3:0] s_retired;

  multicycle_ctrl_fsm_if sif();

  multicycle_ctrl_fsm #(.OPCODE_W(6), .ALUOP_W(4), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(s_rst_n), .opcode(6'd0),
    .flag_c(1'b0), .flag_z(1'b0), .flag_s(1'b0),
    .mem(sif.master),
    .ir_write(s_ir_write), .RegWrite(s_RegWrite), .RegDst(s_RegDst),
    .MemToReg(s_MemToReg), .ALUop(s_ALUop), .pc_write(s_pc_write),
    .AddrSel(s_AddrSel), .illegal(s_illegal), .retired(s_retired)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [5:0] op;
    logic       fc, fz, fs;
    logic       e_pcw;
    logic [1:0] e_asel;
    logic       e_rw;
    logic [1:0] e_rdst, e_m2r;
    logic [3:0] e_aluop;
    logic       has_wb;
  } vec_t;

  vec_t vt[14];
  logic [31:0] exp_ret;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //        op  fc fz fs  pcw asel rw rdst m2r aluop wb
    vt[0]  = '{6'd0,  0,0,0, 0, 2'd0, 0, 2'd0, 2'd0, 4'd0, 1};
    vt[1]  = '{6'd1,  0,0,0, 0, 2'd0, 0, 2'd0, 2'd0, 4'd1, 1};
    vt[2]  = '{6'd4,  0,0,0, 1, 2'd1, 0, 2'd0, 2'd0, 4'd3, 0};
    vt[3]  = '{6'd5,  0,0,1, 1, 2'd2, 0, 2'd0, 2'd0, 4'd3, 0};
    vt[4]  = '{6'd5,  0,0,0, 0, 2'd2, 0, 2'd0, 2'd0, 4'd3, 0};
    vt[5]  = '{6'd6,  0,1,0, 1, 2'd2, 0, 2'd0, 2'd0, 4'd3, 0};
    vt[6]  = '{6'd6,  0,0,0, 0, 2'd2, 0, 2'd0, 2'd0, 4'd3, 0};
    vt[7]  = '{6'd7,  0,0,0, 1, 2'd2, 0, 2'd0, 2'd0, 4'd3, 0};
    vt[8]  = '{6'd7,  0,1,0, 0, 2'd2, 0, 2'd0, 2'd0, 4'd3, 0};
    vt[9]  = '{6'd8,  0,0,0, 1, 2'd3, 0, 2'd0, 2'd0, 4'd3, 0};
    vt[10] = '{6'd9,  0,0,0, 1, 2'd3, 1, 2'd2, 2'd2, 4'd3, 0};
    vt[11] = '{6'd10, 1,0,0, 1, 2'd3, 0, 2'd0, 2'd0, 4'd3, 0};
    vt[12] = '{6'd11, 1,0,0, 0, 2'd3, 0, 2'd0, 2'd0, 4'd3, 0};
    vt[13] = '{6'd11, 0,0,0, 1, 2'd3, 0, 2'd0, 2'd0, 4'd3, 0};

    rst_n = 1'b0; s_rst_n = 1'b0;
    opcode = 6'd0; flag_c = 0; flag_z = 0; flag_s = 0;
    mif.imem_ready = 1'b0; mif.dmem_ready = 1'b0;
    sif.imem_ready = 1'b1; sif.dmem_ready = 1'b0;
    step();

    // reset state
    chk("rst_state",    32'(dut.state), 32'(S_IDLE));
    chk("rst_imem_req", 32'(mif.imem_req), 32'd0);
    chk("rst_outs",     {ir_write, RegWrite, pc_write, illegal, RegDst, MemToReg, AddrSel, ALUop}, 32'd0);
    chk("rst_retired",  retired, 32'd0);

    // release, ALU op with imem_ready tied 1: IDLE FETCH DECODE EXEC WB
    rst_n = 1'b1; mif.imem_ready = 1'b1;
    step();
    chk("alu_fetch_state", 32'(dut.state), 32'(S_FETCH));
    chk("alu_fetch_outs", {mif.imem_req, ir_write, pc_write, AddrSel}, {27'd0, 1'b1, 1'b1, 1'b1, 2'd0});
    step();
    chk("alu_decode_state", 32'(dut.state), 32'(S_DECODE));
    chk("alu_decode_req", 32'(mif.imem_req), 32'd0);
    step();
    chk("alu_exec_state", 32'(dut.state), 32'(S_EXEC));
    chk("alu_exec_rw", 32'(RegWrite), 32'd0);
    step();
    chk("alu_wb_state", 32'(dut.state), 32'(S_WB));
    chk("alu_wb_rw", {RegWrite, RegDst, MemToReg}, {27'd0, 1'b1, 2'd0, 2'd0});
    step();
    chk("alu_retired", retired, 32'd1);
    exp_ret = 32'd1;

    // table-driven single instructions, each starting in FETCH
    for (int i = 0; i < 14; i++) begin
      opcode = vt[i].op; flag_c = vt[i].fc; flag_z = vt[i].fz; flag_s = vt[i].fs;
      step();
      chk($sformatf("v%0d_decode", i), 32'(dut.state), 32'(S_DECODE));
      step();
      chk($sformatf("v%0d_exec_pcw", i), 32'(pc_write), 32'(vt[i].e_pcw));
      if (vt[i].e_pcw)
        chk($sformatf("v%0d_exec_asel", i), 32'(AddrSel), 32'(vt[i].e_asel));
      chk($sformatf("v%0d_exec_rw", i), {RegWrite, RegDst, MemToReg},
          {27'd0, vt[i].e_rw, vt[i].e_rdst, vt[i].e_m2r});
      chk($sformatf("v%0d_exec_aluop", i), 32'(ALUop), 32'(vt[i].e_aluop));
      if (vt[i].has_wb) begin
        step();
        chk($sformatf("v%0d_wb", i), {RegWrite, RegDst, MemToReg}, {27'd0, 1'b1, 2'd0, 2'd0});
      end
      step();
      exp_ret++;
      chk($sformatf("v%0d_fetch", i), 32'(mif.imem_req), 32'd1);
      chk($sformatf("v%0d_retired", i), retired, exp_ret);
    end
    flag_c = 0; flag_z = 0; flag_s = 0;

    // lw with dmem_ready delayed: three MEM cycles
    opcode = 6'd2;
    step(); step();
    chk("lw_exec_aluop", 32'(ALUop), 32'd2);
    chk("lw_exec_noreq", 32'(mif.dmem_req), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("lw_mem%0d", k), {mif.dmem_req, mif.MemRead, mif.MemWrite}, 32'b110);
      if (k == 2) mif.dmem_ready = 1'b1;
    end
    step();
    chk("lw_wb", {RegWrite, RegDst, MemToReg, mif.dmem_req}, {27'd0, 1'b1, 2'd1, 2'd1, 1'b0});
    chk("lw_wb_retired", retired, exp_ret);
    step();
    exp_ret++;
    chk("lw_retired", retired, exp_ret);

    // sw with zero-wait data memory
    opcode = 6'd3;
    step(); step(); step();
    chk("sw_mem", {mif.dmem_req, mif.MemRead, mif.MemWrite}, 32'b101);
    step();
    exp_ret++;
    chk("sw_fetch", 32'(dut.state), 32'(S_FETCH));
    chk("sw_retired", retired, exp_ret);
    mif.dmem_ready = 1'b0;

    // instruction fetch wait
    mif.imem_ready = 1'b0; opcode = 6'd0;
    step();
    chk("fetch_wait", {mif.imem_req, ir_write, pc_write}, 32'b100);
    chk("fetch_wait_state", 32'(dut.state), 32'(S_FETCH));
    mif.imem_ready = 1'b1;

    // reset mid-MEM: request drops without a clock edge
    opcode = 6'd2;
    step(); step(); step();
    chk("mrst_mem_req", 32'(mif.dmem_req), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_req_drop", {mif.dmem_req, mif.MemRead}, 32'd0);
    chk("mrst_state", 32'(dut.state), 32'(S_IDLE));
    chk("mrst_retired", retired, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("mrst_refetch", 32'(dut.state), 32'(S_FETCH));

    // illegal opcode
    opcode = 6'h3F;
    step(); step();
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("ill_trap_state", 32'(dut.state), 32'(S_TRAP));
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("ill_trap%0d", k), {illegal, mif.imem_req, mif.dmem_req}, 32'b100);
      step();
    end
    chk("ill_trap_retired", retired, 32'd0);
`else
    chk("ill_nop_state", 32'(dut.state), 32'(S_FETCH));
    chk("ill_nop_retired", retired, 32'd1);
    chk("ill_nop_flag", 32'(illegal), 32'd0);
`endif

    // narrow counter: 17 ALU ops wrap a 4-bit count to 1
    s_rst_n = 1'b1;
    step();
    for (int n = 1; n <= 17; n++) begin
      step(); step(); step(); step();
      if (n == 15) chk("wrap_n15", 32'(s_retired), 32'd15);
      if (n == 16) chk("wrap_n16", 32'(s_retired), 32'd0);
      if (n == 17) chk("wrap_n17", 32'(s_retired), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Multicycle control sequencer for the KGPminiRISC datapath, the successor to the single-cycle opcode decoder. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and handshakes with instruction and data memory (req/ready). It drives the datapath select and enable signals per state, resolves conditional branches from latched ALU flags, and counts retired instructions. It sits between the memories and the register file/ALU/PC datapath.

## Interface
- OPCODE_W, 6, opcode field width; opcodes 0–11 are legal, all others are illegal.
- ALUOP_W, 4, ALUop output width.
- CNT_W, 32, retired-instruction counter width.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  OPCODE_W  opcode field of the instruction register (IR), valid from DECODE onward
- flag_c, flag_z, flag_s  in  1 each  latched ALU carry, zero and sign flags
- imem_ready  in  1  instruction word available
- dmem_ready  in  1  data access complete
- imem_req  out  1  instruction fetch request
- ir_write  out  1  load the IR
- dmem_req  out  1  data memory request
- MemRead, MemWrite  out  1 each  data direction, valid with dmem_req
- RegWrite  out  1  register file write enable
- RegDst  out  2  destination select: 00 rd, 01 rt, 10 link register
- MemToReg  out  2  write-back select: 00 ALU, 01 memory, 10 PC+4
- ALUop  out  ALUOP_W  ALU operation class
- pc_write  out  1  PC update enable
- AddrSel  out  2  next-PC source: 00 PC+4, 01 register, 10 PC-relative, 11 absolute immediate
- illegal  out  1  illegal opcode trapped
- retired  out  CNT_W  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE: all outputs are 0. The block moves to FETCH on the first clock edge after rst_n is released.
- FETCH: imem_req=1.
  - When imem_ready=1: ir_write=1, pc_write=1, AddrSel=00. Next state is DECODE.
  - When imem_ready=0: hold in FETCH.
- DECODE: one cycle. A legal opcode goes to EXEC. An illegal opcode is handled per Configuration.
- EXEC: ALUop is driven from the opcode (00 reg-ALU, 01 imm-ALU, 10 address, 11 branch, zero-extended to ALUOP_W).
  - ALU ops (0, 1) → WB.
  - lw (2), sw (3) → MEM.
  - br (4): pc_write=1, AddrSel=01.
  - bltz (5): taken if flag_s. bz (6): taken if flag_z. bnz (7): taken if !flag_z.
  - b (8): AddrSel=11, always taken.
  - bl (9): AddrSel=11 and RegWrite=1, RegDst=10, MemToReg=10, all in the same cycle.
  - bcy (10): taken if flag_c. bncy (11): taken if !flag_c.
  - Conditional branches 5–7 use AddrSel=10. Conditional branches 10–11 use AddrSel=11.
  - A conditional branch asserts pc_write only when taken.
  - Every branch returns to FETCH and retires.
- MEM: dmem_req=1, with MemRead=1 for lw and MemWrite=1 for sw. Hold in MEM until dmem_ready. Then lw → WB, sw → FETCH and retires.
- WB: RegWrite=1 for exactly one cycle.
  - ALU ops: RegDst=00, MemToReg=00.
  - lw: RegDst=01, MemToReg=01.
  - Returns to FETCH and retires.
- Outputs not listed for a state are 0.
- retired increments by 1 on each retirement and wraps modulo 2^CNT_W.

## Timing
- Outputs are Moore-decoded from the state register and the IR opcode. There are no registered output delays.
- Zero-wait memory latencies: branch 3 cycles, ALU op and sw 4 cycles, lw 5 cycles. Each wait cycle adds 1.
- A ready asserted in the same cycle as the req is accepted.
- ready while req=0 is ignored.
- req and the MemRead/MemWrite direction stay stable until ready.
- rst_n asserted mid-instruction immediately forces IDLE, deasserts all requests and clears retired and illegal. Pending memory transactions are abandoned.
- Reset values: state=IDLE, every output 0, retired=0.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: an illegal opcode in DECODE moves to TRAP. TRAP holds illegal=1, issues no requests and does not increment retired. Only reset exits TRAP.
- CTRL_ILLEGAL_TRAP_EN undefined: an illegal opcode is a NOP. DECODE → FETCH, retired increments, and illegal is tied to 0.

## Structure
- Package ctrl_pkg holds:
  - the state enum;
  - opcode localparams (OP_ALU … OP_BNCY);
  - ALUop class, AddrSel, RegDst and MemToReg encodings.
- Sub-module branch_cond_eval: combinational; takes opcode and the three flags and outputs taken and AddrSel.

## Test plan
- Reset release, then ALU op (opcode 0) with imem_ready tied 1 → states IDLE, FETCH, DECODE, EXEC, WB. RegWrite=1 in the 5th cycle. retired=1.
- lw (2) with dmem_ready delayed 3 cycles → dmem_req and MemRead held 3 cycles, then WB with RegDst=01, MemToReg=01. retired increments once.
- bz (6): flag_z=1 gives pc_write=1, AddrSel=10 in EXEC. flag_z=0 gives pc_write=0 in EXEC. Both return to FETCH.
- bl (9) → in EXEC: pc_write=1, AddrSel=11, RegWrite=1, RegDst=10, MemToReg=10.
- Opcode 6'h3F with CTRL_ILLEGAL_TRAP_EN → TRAP, illegal=1, imem_req stays 0 for 10 cycles. Without the macro → FETCH follows DECODE and retired increments.
- rst_n asserted while in MEM with dmem_req=1 → dmem_req drops asynchronously, retired=0, state=IDLE. CNT_W=4 run of 17 ALU ops → retired=1.
